quad_decoder: RTL and testbench

Quadrature encoder front end that feeds the up/down counter stage. It synchronises and glitch-filters the asynchronous A/B encoder lines, then decodes the Gray-code sequence. It emits a one-cycle step pulse (counter enable) with a direction level, plus error flags for illegal transitions. All logic runs in the counter's clock domain.

---
 rtl/quad_decoder.sv | 144 ++++++++++++++
 tb/tb_quad_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronises and glitch-filters A/B, then decodes
// Gray-code transitions into step/dir pulses and illegal-transition error flags.
module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic err_clr,
    output logic step,
    output logic dir,
    output logic err,
    output logic err_sticky
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam int IW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t state, state_next;

    logic [IW-1:0]          init_cnt;
    logic                   load;
    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             sync_ab;
    logic [1:0]             filt_ab;
    logic [1:0]             prev_ab;
    logic [CW-1:0]          filt_cnt [2];

    assign sync_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // INIT waits until the synchroniser chains hold real samples, then seeds
    // filter and previous state so the rest position never produces a step.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == IW'(SYNC_STAGES)) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt <= '0;
        end else if (state == INIT && !load) begin
            init_cnt <= init_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
        end
    end

    // Index 1 is channel A, index 0 is channel B.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_ab     <= '0;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else if (load) begin
            filt_ab     <= sync_ab;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < 2; i++) begin
                if (sync_ab[i] == filt_ab[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == CW'(FILT_LEN - 1)) begin
                    filt_ab[i]  <= sync_ab[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + CW'(1);
                end
            end
        end
    end

    // For a single-bit change, new A differing from old B means A leads B.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_ab <= '0;
            step    <= 1'b0;
            dir     <= 1'b0;
            err     <= 1'b0;
        end else if (load) begin
            prev_ab <= sync_ab;
            step    <= 1'b0;
            err     <= 1'b0;
        end else if (state == RUN) begin
            prev_ab <= filt_ab;
            step    <= 1'b0;
            err     <= 1'b0;
            case (filt_ab ^ prev_ab)
                2'b01, 2'b10: begin
                    step <= 1'b1;
                    dir  <= filt_ab[1] ^ prev_ab[0];
                end
                2'b11:   err <= 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sticky <= 1'b0;
        end else if (err) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: reset/INIT, increment, decrement, glitch rejection,
// illegal transitions with sticky flag, and reset in the middle of a filter count.
module tb_quad_decoder;

    logic clk;
    logic reset;
    logic enc_a;
    logic enc_b;
    logic err_clr;
    logic step;
    logic dir;
    logic err;
    logic err_sticky;

    int total;
    int bad;
    int steps;
    int dir_ones;
    int errs;
    logic last_dir;

    quad_decoder #(.SYNC_STAGES(2), .FILT_LEN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .err_clr    (err_clr),
        .step       (step),
        .dir        (dir),
        .err        (err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (step === 1'b1) begin
            steps++;
            if (dir === 1'b1) dir_ones++;
            last_dir = dir;
        end
        if (err === 1'b1) errs++;
    endtask

    task automatic applyStimulus(input logic a, input logic b, input int n);
        enc_a = a;
        enc_b = b;
        repeat (n) tick();
    endtask

    task automatic clearCounts();
        steps    = 0;
        dir_ones = 0;
        errs     = 0;
    endtask

    initial begin
        clk     = 1'b0;
        reset   = 1'b0;
        enc_a   = 1'b1;
        enc_b   = 1'b1;
        err_clr = 1'b0;
        total   = 0;
        bad     = 0;
        last_dir = 1'b0;
        clearCounts();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset step", {31'd0, step}, 32'd0);
        checkOutput("reset dir", {31'd0, dir}, 32'd0);
        checkOutput("reset err", {31'd0, err}, 32'd0);
        checkOutput("reset sticky", {31'd0, err_sticky}, 32'd0);
        checkOutput("reset filt", {30'd0, dut.filt_ab}, 32'd0);

        reset = 1'b1;
        repeat (3) tick();
        checkOutput("init filt 11", {30'd0, dut.filt_ab}, 32'd3);
        repeat (17) tick();
        checkOutput("init no step", steps, 0);
        checkOutput("init no err", errs, 0);

        $display("[TB] increment sequence");
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 2);
        reset = 1'b1;
        clearCounts();
        repeat (20) tick();
        checkOutput("rest00 no step", steps, 0);
        enc_a = 1'b1;
        repeat (6) tick();
        checkOutput("inc latency early", {31'd0, step}, 32'd0);
        tick();
        checkOutput("inc latency step", {31'd0, step}, 32'd1);
        checkOutput("inc latency dir", {31'd0, dir}, 32'd1);
        tick();
        checkOutput("inc pulse width", {31'd0, step}, 32'd0);
        repeat (2) tick();
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("inc step count", steps, 4);
        checkOutput("inc dir count", dir_ones, 4);
        checkOutput("inc no err", errs, 0);

        $display("[TB] decrement sequence");
        clearCounts();
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("dec step count", steps, 4);
        checkOutput("dec dir count", dir_ones, 0);
        repeat (5) tick();
        checkOutput("dec idle step", {31'd0, step}, 32'd0);
        checkOutput("dec dir held", {31'd0, dir}, 32'd0);

        $display("[TB] glitch rejection");
        clearCounts();
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 15);
        checkOutput("glitch3 no step", steps, 0);
        checkOutput("glitch3 no err", errs, 0);
        clearCounts();
        applyStimulus(1'b1, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("pulse4 steps", steps, 2);
        checkOutput("pulse4 dir ones", dir_ones, 1);
        checkOutput("pulse4 last dir", {31'd0, last_dir}, 32'd0);

        $display("[TB] illegal transitions");
        clearCounts();
        checkOutput("sticky before", {31'd0, err_sticky}, 32'd0);
        applyStimulus(1'b1, 1'b1, 12);
        checkOutput("illegal err count", errs, 1);
        checkOutput("illegal no step", steps, 0);
        checkOutput("illegal sticky", {31'd0, err_sticky}, 32'd1);
        checkOutput("illegal dir held", {31'd0, dir}, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("sticky cleared", {31'd0, err_sticky}, 32'd0);
        enc_a = 1'b0;
        enc_b = 1'b0;
        for (int i = 0; i < 20 && err !== 1'b1; i++) tick();
        checkOutput("second err seen", {31'd0, err}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("sticky set wins", {31'd0, err_sticky}, 32'd1);
        repeat (3) tick();
        checkOutput("sticky holds", {31'd0, err_sticky}, 32'd1);

        $display("[TB] reset mid-filter");
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("pre-reset dir", {31'd0, dir}, 32'd1);
        applyStimulus(1'b1, 1'b1, 2);
        reset = 1'b0;
        #1;
        checkOutput("midrst step", {31'd0, step}, 32'd0);
        checkOutput("midrst dir", {31'd0, dir}, 32'd0);
        checkOutput("midrst err", {31'd0, err}, 32'd0);
        checkOutput("midrst sticky", {31'd0, err_sticky}, 32'd0);
        checkOutput("midrst filt", {30'd0, dut.filt_ab}, 32'd0);
        tick();
        reset = 1'b1;
        clearCounts();
        repeat (20) tick();
        checkOutput("post-rst no step", steps, 0);
        checkOutput("post-rst no err", errs, 0);
        checkOutput("post-rst filt", {30'd0, dut.filt_ab}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
